uart_tx_word: RTL and testbench

- Multi-byte UART transmitter that consumes the send_en/send_data[63:0] pair produced by the UART loopback controller and returns tx_busy to it.
- On a rising edge of send_en it captures a 64-bit word and serialises NUM_BYTES bytes back-to-back on uart_txd as 8N1 frames, least-significant byte first.
- Sits directly downstream of the loopback controller and drives the board TX pin.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_byte_tx.sv | 106 ++++++++++
 rtl/uart_tx_word.sv | 89 ++++++++
 tb/tb_uart_tx_word.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions: serialiser state encoding, 8N1
//                frame size and the baud divisor calculation.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Serialiser state encoding
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_DATA  = 2'd2;
    localparam logic [1:0] c_ST_STOP  = 2'd3;

    // 8N1: one start bit, eight data bits, one stop bit
    localparam int c_FRAME_BITS = 10;

    // Clocks per bit; shared with the receiver so both ends agree
    function automatic int calc_bps_cnt(input int clk_freq, input int uart_bps);
        return clk_freq / uart_bps;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_byte_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_byte_tx
//  Description : Single-byte 8N1 serialiser. Accepts a byte when idle or in
//                the last cycle of a stop bit, so consecutive bytes can be
//                sent without an idle gap. byte_done marks that last cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int BPS_CNT = 434
)
(
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_done,
    output logic       txd
);

    localparam int                 c_CNT_W     = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
    localparam logic [c_CNT_W-1:0] c_BAUD_LAST = c_CNT_W'(BPS_CNT - 1);

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_baud_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic               r_txd;

    logic w_bit_end;
    logic w_accept;

    assign w_bit_end = (r_baud_cnt == c_BAUD_LAST);
    // Last cycle of the stop bit: the upstream may hand over the next byte now
    assign byte_done = (r_state == c_ST_STOP) && w_bit_end;
    assign w_accept  = byte_valid && ((r_state == c_ST_IDLE) || byte_done);
    assign txd       = r_txd;

    // Bit-timing state machine; the line level is registered for a clean pin
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state    <= c_ST_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'h00;
            r_txd      <= 1'b1;
        end else if (w_accept) begin
            r_state    <= c_ST_START;
            r_baud_cnt <= '0;
            r_bit_idx  <= 3'd0;
            r_shift    <= byte_data;
            r_txd      <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_baud_cnt <= '0;
                    r_txd      <= 1'b1;
                end
                c_ST_START: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        r_bit_idx  <= 3'd0;
                        r_txd      <= r_shift[0];
                        r_shift    <= r_shift >> 1;
                        r_state    <= c_ST_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                c_ST_DATA: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_txd   <= 1'b1;
                            r_state <= c_ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_txd     <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                c_ST_STOP: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        r_txd      <= 1'b1;
                        r_state    <= c_ST_IDLE;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                default: begin
                    r_baud_cnt <= '0;
                    r_txd      <= 1'b1;
                    r_state    <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_word.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_word
//  Description : Multi-byte UART transmitter. A rising edge of send_en
//                captures a 64-bit word and sends NUM_BYTES bytes, LSB
//                first, as back-to-back 8N1 frames on uart_txd.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_word
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int UART_BPS  = 115200,
    parameter int NUM_BYTES = 8
)
(
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        send_en,
    input  logic [63:0] send_data,
    output logic        tx_busy,
    output logic        uart_txd
);

    localparam int         c_BPS_CNT   = calc_bps_cnt(CLK_FREQ, UART_BPS);
    localparam logic [2:0] c_LAST_BYTE = 3'(NUM_BYTES - 1);

    logic        r_en_d0;
    logic        r_en_d1;
    logic        r_busy;
    logic [2:0]  r_byte_idx;
    logic [63:0] r_data_reg;   // bytes still waiting to go out, next one in [7:0]

    logic        w_start_flag;
    logic        w_start;
    logic        w_more;
    logic        w_byte_done;
    logic        w_byte_valid;
    logic [7:0]  w_byte_data;

    assign w_start_flag = r_en_d0 & ~r_en_d1;
    // A start during a word, including its final cycle, is dropped
    assign w_start      = w_start_flag & ~r_busy;
    assign w_more       = (r_byte_idx < c_LAST_BYTE);
    assign w_byte_valid = w_start | (w_byte_done & w_more);
    // The first byte bypasses the capture register so the start bit is not delayed
    assign w_byte_data  = r_busy ? r_data_reg[7:0] : send_data[7:0];

    assign tx_busy = r_busy;

    // Edge detect on send_en, word capture and byte sequencing
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_en_d0    <= 1'b0;
            r_en_d1    <= 1'b0;
            r_busy     <= 1'b0;
            r_byte_idx <= 3'd0;
            r_data_reg <= 64'h0;
        end else begin
            r_en_d0 <= send_en;
            r_en_d1 <= r_en_d0;
            if (w_start) begin
                r_busy     <= 1'b1;
                r_byte_idx <= 3'd0;
                r_data_reg <= {8'h00, send_data[63:8]};
            end else if (r_busy && w_byte_done) begin
                if (w_more) begin
                    r_byte_idx <= r_byte_idx + 3'd1;
                    r_data_reg <= {8'h00, r_data_reg[63:8]};
                end else begin
                    r_busy <= 1'b0;
                end
            end
        end
    end

    uart_byte_tx #(
        .BPS_CNT    (c_BPS_CNT)
    ) u_byte_tx (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .byte_valid (w_byte_valid),
        .byte_data  (w_byte_data),
        .byte_done  (w_byte_done),
        .txd        (uart_txd)
    );

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_word.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_word
//  Description : Self-checking bench for uart_tx_word. Expected bytes are
//                queued when a word is launched; line monitors decode the
//                serial output and compare each frame against the queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_word;
    import uart_pkg::*;

    localparam int BPS   = 10;
    localparam int LEN_A = 8 * c_FRAME_BITS * BPS;
    localparam int LEN_B = 1 * c_FRAME_BITS * BPS;

    logic        clk = 1'b0;
    logic        rst_a, en_a, busy_a, txd_a;
    logic [63:0] data_a;
    logic        rst_b, en_b, busy_b, txd_b;
    logic [63:0] data_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q_a[$];
    logic [7:0] exp_q_b[$];

    always #5 clk = ~clk;

    uart_tx_word #(
        .CLK_FREQ  (1_000_000),
        .UART_BPS  (100_000),
        .NUM_BYTES (8)
    ) u_dut_a (
        .sys_clk   (clk),
        .sys_rst   (rst_a),
        .send_en   (en_a),
        .send_data (data_a),
        .tx_busy   (busy_a),
        .uart_txd  (txd_a)
    );

    uart_tx_word #(
        .CLK_FREQ  (1_000_000),
        .UART_BPS  (100_000),
        .NUM_BYTES (1)
    ) u_dut_b (
        .sys_clk   (clk),
        .sys_rst   (rst_b),
        .send_en   (en_b),
        .send_data (data_b),
        .tx_busy   (busy_b),
        .uart_txd  (txd_b)
    );

    // Line monitor A: sample each bit mid-cell and score the frame
    logic       mon_a_active = 1'b0;
    int         mon_a_cnt    = 0;
    logic [9:0] mon_a_bits;
    logic [7:0] mon_a_exp;
    always @(negedge clk) begin
        if (rst_a === 1'b1) begin
            mon_a_active = 1'b0;
        end else if (!mon_a_active) begin
            if (txd_a === 1'b0) begin
                mon_a_active = 1'b1;
                mon_a_cnt    = 0;
                mon_a_bits   = '0;
            end
        end else begin
            mon_a_cnt++;
        end
        if (mon_a_active && (mon_a_cnt % BPS == BPS / 2))
            mon_a_bits[mon_a_cnt / BPS] = txd_a;
        if (mon_a_active && (mon_a_cnt == 9 * BPS + BPS / 2)) begin
            mon_a_active = 1'b0;
            n_checks++;
            if (exp_q_a.size() == 0) begin
                n_fail++;
                $display("FAIL frame_a_unexpected: got frame bits %b, required no frame", mon_a_bits);
            end else begin
                mon_a_exp = exp_q_a.pop_front();
                if (mon_a_bits !== {1'b1, mon_a_exp, 1'b0}) begin
                    n_fail++;
                    $display("FAIL frame_a: got frame bits %b, required %b", mon_a_bits, {1'b1, mon_a_exp, 1'b0});
                end
            end
        end
    end

    // Line monitor B: same decoder for the single-byte instance
    logic       mon_b_active = 1'b0;
    int         mon_b_cnt    = 0;
    logic [9:0] mon_b_bits;
    logic [7:0] mon_b_exp;
    always @(negedge clk) begin
        if (rst_b === 1'b1) begin
            mon_b_active = 1'b0;
        end else if (!mon_b_active) begin
            if (txd_b === 1'b0) begin
                mon_b_active = 1'b1;
                mon_b_cnt    = 0;
                mon_b_bits   = '0;
            end
        end else begin
            mon_b_cnt++;
        end
        if (mon_b_active && (mon_b_cnt % BPS == BPS / 2))
            mon_b_bits[mon_b_cnt / BPS] = txd_b;
        if (mon_b_active && (mon_b_cnt == 9 * BPS + BPS / 2)) begin
            mon_b_active = 1'b0;
            n_checks++;
            if (exp_q_b.size() == 0) begin
                n_fail++;
                $display("FAIL frame_b_unexpected: got frame bits %b, required no frame", mon_b_bits);
            end else begin
                mon_b_exp = exp_q_b.pop_front();
                if (mon_b_bits !== {1'b1, mon_b_exp, 1'b0}) begin
                    n_fail++;
                    $display("FAIL frame_b: got frame bits %b, required %b", mon_b_bits, {1'b1, mon_b_exp, 1'b0});
                end
            end
        end
    end

    task automatic push_word_a(input logic [63:0] w);
        for (int i = 0; i < 8; i++) exp_q_a.push_back(w[8*i +: 8]);
    endtask

    // Raise en_a and check the two-clock start latency
    task automatic launch_a(input string name);
        @(negedge clk);
        en_a = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_latency_early: tx_busy=%b, required 0", name, busy_a);
        end
        @(negedge clk);
        n_checks++;
        if (busy_a !== 1'b1 || txd_a !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_start: tx_busy=%b uart_txd=%b, required 1 and 0", name, busy_a, txd_a);
        end
    endtask

    task automatic test_reset;
        int len = 1;
        int extra = 0;
        bit done = 0;
        rst_a = 1'b1; en_a = 1'b1; data_a = 64'h0807_0605_0403_0201;
        rst_b = 1'b1; en_b = 1'b0; data_b = 64'h0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i > 0) begin
                n_checks++;
                if (txd_a !== 1'b1 || busy_a !== 1'b0 || txd_b !== 1'b1 || busy_b !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_state: txd_a=%b busy_a=%b txd_b=%b busy_b=%b, required 1 0 1 0",
                             txd_a, busy_a, txd_b, busy_b);
                end
            end
        end
        push_word_a(data_a);
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_early: tx_busy=%b, required 0", busy_a);
        end
        @(negedge clk);
        n_checks++;
        if (busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_start: tx_busy=%b, required 1", busy_a);
        end
        for (int c = 0; c < 2000 && !done; c++) begin
            @(negedge clk);
            if (busy_a === 1'b1) len++; else done = 1;
        end
        n_checks++;
        if (len != LEN_A) begin
            n_fail++;
            $display("FAIL reset_release_len: busy cycles=%0d, required %0d", len, LEN_A);
        end
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (busy_a !== 1'b0) extra++;
        end
        n_checks++;
        if (extra != 0 || exp_q_a.size() != 0) begin
            n_fail++;
            $display("FAIL reset_release_once: busy after word=%0d cycles, pending bytes=%0d, required 0 and 0",
                     extra, exp_q_a.size());
        end
        en_a = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_basic;
        int len = 1;
        bit done = 0;
        data_a = 64'h0807_0605_0403_0201;
        push_word_a(data_a);
        launch_a("basic");
        for (int c = 0; c < 2000 && !done; c++) begin
            @(negedge clk);
            if (busy_a === 1'b1) len++; else done = 1;
        end
        n_checks++;
        if (len != LEN_A || txd_a !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_len: busy cycles=%0d txd=%b, required %0d and 1", len, txd_a, LEN_A);
        end
        en_a = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (exp_q_a.size() != 0) begin
            n_fail++;
            $display("FAIL basic_bytes: pending bytes=%0d, required 0", exp_q_a.size());
        end
    endtask

    task automatic test_ignore_busy;
        int len = 1;
        int extra = 0;
        bit done = 0;
        data_a = 64'h1122_3344_5566_7788;
        push_word_a(data_a);
        launch_a("ignore");
        for (int c = 0; c < 2000 && !done; c++) begin
            @(negedge clk);
            if (busy_a === 1'b1) len++; else done = 1;
            if (len == 300) en_a = 1'b0;
            if (len == 301) en_a = 1'b1;
        end
        n_checks++;
        if (len != LEN_A) begin
            n_fail++;
            $display("FAIL ignore_len: busy cycles=%0d, required %0d", len, LEN_A);
        end
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (busy_a !== 1'b0 || txd_a !== 1'b1) extra++;
        end
        n_checks++;
        if (extra != 0 || exp_q_a.size() != 0) begin
            n_fail++;
            $display("FAIL ignore_retrigger: active cycles=%0d pending bytes=%0d, required 0 and 0",
                     extra, exp_q_a.size());
        end
        en_a = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_data_hold;
        int len = 1;
        bit done = 0;
        data_a = 64'h0807_0605_0403_0201;
        push_word_a(data_a);
        launch_a("hold");
        for (int c = 0; c < 2000 && !done; c++) begin
            @(negedge clk);
            if (busy_a === 1'b1) len++; else done = 1;
            if (len == 100) data_a = 64'hDEAD_BEEF_0000_0000;
        end
        n_checks++;
        if (len != LEN_A) begin
            n_fail++;
            $display("FAIL hold_len: busy cycles=%0d, required %0d", len, LEN_A);
        end
        en_a = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (exp_q_a.size() != 0) begin
            n_fail++;
            $display("FAIL hold_bytes: pending bytes=%0d, required 0", exp_q_a.size());
        end
    endtask

    task automatic test_reset_mid;
        int len = 1;
        int low = 0;
        bit done = 0;
        data_a = 64'h0807_0605_0403_0201;
        push_word_a(data_a);
        launch_a("midrst");
        for (int c = 0; c < 249; c++) @(negedge clk);
        rst_a = 1'b1;
        en_a  = 1'b0;
        @(negedge clk);
        n_checks++;
        if (txd_a !== 1'b1 || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_abort: uart_txd=%b tx_busy=%b, required 1 and 0", txd_a, busy_a);
        end
        n_checks++;
        if (exp_q_a.size() != 6) begin
            n_fail++;
            $display("FAIL midrst_sent: pending bytes=%0d, required 6", exp_q_a.size());
        end
        exp_q_a.delete();
        @(negedge clk);
        rst_a = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (txd_a !== 1'b1 || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_idle: uart_txd=%b tx_busy=%b, required 1 and 0", txd_a, busy_a);
        end
        data_a = 64'hFFFF_FFFF_FFFF_FFFF;
        push_word_a(data_a);
        launch_a("midrst_ff");
        low = 1;
        for (int c = 0; c < 2000 && !done; c++) begin
            @(negedge clk);
            if (busy_a === 1'b1) begin
                len++;
                if (txd_a === 1'b0) low++;
            end else begin
                done = 1;
            end
        end
        n_checks++;
        if (len != LEN_A || low != 8 * BPS) begin
            n_fail++;
            $display("FAIL midrst_ff: busy cycles=%0d low cycles=%0d, required %0d and %0d",
                     len, low, LEN_A, 8 * BPS);
        end
        en_a = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (exp_q_a.size() != 0) begin
            n_fail++;
            $display("FAIL midrst_bytes: pending bytes=%0d, required 0", exp_q_a.size());
        end
    endtask

    task automatic test_one_byte;
        int len = 1;
        int low = 1;
        int bad = 0;
        int idle_low = 0;
        bit seen_high = 0;
        bit done = 0;
        data_b = 64'h0;
        exp_q_b.push_back(8'h00);
        @(negedge clk);
        en_b = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (busy_b !== 1'b1 || txd_b !== 1'b0) begin
            n_fail++;
            $display("FAIL one_start: tx_busy=%b uart_txd=%b, required 1 and 0", busy_b, txd_b);
        end
        for (int c = 0; c < 500 && !done; c++) begin
            @(negedge clk);
            if (busy_b === 1'b1) begin
                len++;
                if (txd_b === 1'b0) begin
                    low++;
                    if (seen_high) bad++;
                end else begin
                    seen_high = 1;
                end
            end else begin
                done = 1;
            end
        end
        n_checks++;
        if (len != LEN_B || low != 9 * BPS || bad != 0) begin
            n_fail++;
            $display("FAIL one_frame: busy=%0d low=%0d late_low=%0d, required %0d %0d 0",
                     len, low, bad, LEN_B, 9 * BPS);
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (txd_b !== 1'b1 || busy_b !== 1'b0) idle_low++;
        end
        n_checks++;
        if (idle_low != 0 || exp_q_b.size() != 0) begin
            n_fail++;
            $display("FAIL one_idle: non-idle cycles=%0d pending=%0d, required 0 and 0",
                     idle_low, exp_q_b.size());
        end
        en_b = 1'b0;
    endtask

    initial begin
        rst_a = 1'b1; en_a = 1'b0; data_a = 64'h0;
        rst_b = 1'b1; en_b = 1'b0; data_b = 64'h0;
        test_reset();
        test_basic();
        test_ignore_busy();
        test_data_hold();
        test_reset_mid();
        test_one_byte();
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
